// File: rtl/oflow_hist_read_pkg.sv
// oflow_hist_read_pkg: FSM state type and default widths shared with the MEM buffer defines
package oflow_hist_read_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} hist_read_state_t;
  localparam int DEF_NUM_HIST = 5;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_FRAME_W = 8;
  localparam int DEF_LANES = 2;
endpackage

// File: rtl/oflow_lane_offset_gen.sv
// oflow_lane_offset_gen: per-lane row offsets and valid mask for one line of a slot
module oflow_lane_offset_gen import oflow_hist_read_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES = DEF_LANES
) (
  input  logic [ADDR_W:0]   base,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] offset [LANES],
  output logic [LANES-1:0]  offset_valid
);
  localparam int AW1 = ADDR_W + 1;
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [ADDR_W:0] s;
    // one extra bit so base+j never wraps below count
    assign s = base + AW1'(j);
    assign offset[j] = s[ADDR_W-1:0];
    assign offset_valid[j] = s < {1'b0, count};
  end
endmodule

// File: rtl/oflow_hist_read_fsm.sv
// oflow_hist_read_fsm: history-buffer read sequencer issuing LANES row offsets per line.
// Define OFLOW_HIST_READ_REVERSE_EN to read slots oldest first.
module oflow_hist_read_fsm import oflow_hist_read_pkg::*; #(
  parameter int NUM_HIST = DEF_NUM_HIST,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int LANES = DEF_LANES,
  parameter int HIST_W = $clog2(NUM_HIST + 1)
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start_read,
  input  logic [FRAME_W-1:0] frame_num,
  input  logic [HIST_W-1:0]  num_of_history_frames,
  input  logic [ADDR_W-1:0]  end_pointers [NUM_HIST],
  input  logic               ready_new_line,
  input  logic               abort,
  output logic               busy,
  output logic               line_valid,
  output logic [ADDR_W-1:0]  offset [LANES],
  output logic [LANES-1:0]   offset_valid,
  output logic [FRAME_W-1:0] frame_to_read,
  output logic [HIST_W-1:0]  hist_idx,
  output logic               done_read
);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [HIST_W-1:0] NH_MAX = HIST_W'(NUM_HIST);
  hist_read_state_t state, state_n;
  logic [HIST_W-1:0] k, k_n, left, left_n, nh_c, first, k_step;
  logic [ADDR_W:0] base, base_n;
  logic [FRAME_W-1:0] fn;
  logic [ADDR_W-1:0] cnt [NUM_HIST];
  logic [ADDR_W-1:0] cur_cnt, nxt_cnt;
  logic [ADDR_W-1:0] gen_off [LANES];
  logic [LANES-1:0] gen_valid;
  assign nh_c = num_of_history_frames > NH_MAX ? NH_MAX : num_of_history_frames;
`ifdef OFLOW_HIST_READ_REVERSE_EN
  assign first = nh_c - HIST_W'(1);
  assign k_step = k - HIST_W'(1);
`else
  assign first = '0;
  assign k_step = k + HIST_W'(1);
`endif
  // k can step one past the table once the last slot is consumed
  assign cur_cnt = k < NH_MAX ? cnt[k] : '0;
  assign nxt_cnt = k_n < NH_MAX ? cnt[k_n] : '0;
  oflow_lane_offset_gen #(.ADDR_W(ADDR_W), .LANES(LANES)) u_gen (
    .base(base_n),
    .count(nxt_cnt),
    .offset(gen_off),
    .offset_valid(gen_valid)
  );
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= IDLE;
      k <= '0;
      left <= '0;
      base <= '0;
      fn <= '0;
      for (int i = 0; i < NUM_HIST; i++) cnt[i] <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
      left <= left_n;
      base <= base_n;
      if (state == IDLE && start_read) begin
        fn <= frame_num;
        cnt <= end_pointers;
      end
    end
  end
  always_comb begin
    state_n = state;
    k_n = k;
    left_n = left;
    base_n = base;
    case (state)
      IDLE: if (start_read) begin
        state_n = nh_c == '0 ? DONE : SCAN;
        k_n = first;
        left_n = nh_c;
      end
      SCAN: if (left == '0) state_n = DONE;
      else if (cur_cnt == '0) begin
        k_n = k_step;
        left_n = left - HIST_W'(1);
      end else begin
        state_n = ISSUE;
        base_n = '0;
      end
      ISSUE: if (ready_new_line) begin
        base_n = base + AW1'(LANES);
        if (base_n >= {1'b0, cur_cnt}) begin
          state_n = SCAN;
          k_n = k_step;
          left_n = left - HIST_W'(1);
        end
      end
      DONE: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // outputs are registered from next-state values so ready_new_line never reaches a port combinationally
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      busy <= 1'b0;
      line_valid <= 1'b0;
      done_read <= 1'b0;
      offset_valid <= '0;
      frame_to_read <= '0;
      hist_idx <= '0;
      for (int i = 0; i < LANES; i++) offset[i] <= '0;
    end else begin
      busy <= state_n != IDLE;
      line_valid <= state_n == ISSUE;
      done_read <= state == DONE && !abort;
      if (state_n == ISSUE) begin
        offset <= gen_off;
        offset_valid <= gen_valid;
        frame_to_read <= fn - FRAME_W'(1) - FRAME_W'(k_n);
        hist_idx <= k_n;
      end
    end
  end
endmodule

// File: tb/tb_oflow_hist_read_fsm.sv
// tb_oflow_hist_read_fsm: scoreboard bench, stimulus pushes expected lines, negedge monitor pops on transfer
module tb_oflow_hist_read_fsm;
  logic clk = 1'b0;
  logic reset_N = 1'b0;
  logic start_read = 1'b0;
  logic ready_new_line = 1'b1;
  logic abort = 1'b0;
  logic [7:0] frame_num = '0;
  logic [2:0] num_of_history_frames = '0;
  logic [7:0] end_pointers [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic busy, line_valid, done_read;
  logic [7:0] offset [2];
  logic [1:0] offset_valid;
  logic [7:0] frame_to_read;
  logic [2:0] hist_idx;
  typedef struct {logic [7:0] f; logic [2:0] idx; logic [7:0] o0; logic [7:0] o1; logic [1:0] m;} line_t;
  line_t q[$];
  line_t e, prev;
  logic hold_prev = 1'b0;
  logic bp_en = 1'b0;
  int ph = 0;
  int n_checks = 0, n_fail = 0, done_seen = 0, done_exp = 0;

  oflow_hist_read_fsm dut (
    .clk(clk), .reset_N(reset_N), .start_read(start_read), .frame_num(frame_num),
    .num_of_history_frames(num_of_history_frames), .end_pointers(end_pointers),
    .ready_new_line(ready_new_line), .abort(abort), .busy(busy), .line_valid(line_valid),
    .offset(offset), .offset_valid(offset_valid), .frame_to_read(frame_to_read),
    .hist_idx(hist_idx), .done_read(done_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_slot(input int f, input int idx, input int cnt);
    for (int b = 0; b < cnt; b += 2)
      q.push_back(line_t'{f: 8'(f), idx: 3'(idx), o0: 8'(b), o1: 8'(b + 1), m: {b + 1 < cnt, 1'b1}});
  endtask

  task automatic push_case1();
`ifdef OFLOW_HIST_READ_REVERSE_EN
    push_slot(9, 2, 5); push_slot(10, 1, 3); push_slot(11, 0, 9);
`else
    push_slot(11, 0, 9); push_slot(10, 1, 3); push_slot(9, 2, 5);
`endif
  endtask

  task automatic start(input logic [7:0] fn, input logic [2:0] nh, input logic [7:0] c0, c1, c2, c3, c4);
    @(posedge clk); #1;
    frame_num = fn;
    num_of_history_frames = nh;
    end_pointers = '{c0, c1, c2, c3, c4};
    start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    frame_num = 8'hA5;
    num_of_history_frames = 3'd1;
    end_pointers = '{8'd200, 8'd0, 8'd7, 8'd50, 8'd33};
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300 && !done_read; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_done"}, done_read, 1);
    chk({name, "_busy_at_done"}, busy, 0);
    done_exp++;
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, done_read, 0);
    chk({name, "_lines_left"}, q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #2;
    ph = (ph + 1) % 4;
    ready_new_line = bp_en ? (ph == 3) : 1'b1;
  end

  always @(negedge clk) if (reset_N) begin
    if (hold_prev) begin
      chk("hold_valid", line_valid, 1);
      chk("hold_off0", offset[0], prev.o0);
      chk("hold_off1", offset[1], prev.o1);
      chk("hold_mask", offset_valid, prev.m);
      chk("hold_frame", frame_to_read, prev.f);
      chk("hold_idx", hist_idx, prev.idx);
    end
    if (line_valid && ready_new_line && !abort) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_line: got frame 0x%0h offset0 %0d, expected no line", frame_to_read, offset[0]);
      end else begin
        e = q.pop_front();
        chk("line_frame", frame_to_read, e.f);
        chk("line_idx", hist_idx, e.idx);
        chk("line_off0", offset[0], e.o0);
        chk("line_off1", offset[1], e.o1);
        chk("line_mask", offset_valid, e.m);
      end
    end
    if (done_read) done_seen++;
    hold_prev = line_valid && !ready_new_line && !abort;
    prev = line_t'{f: frame_to_read, idx: hist_idx, o0: offset[0], o1: offset[1], m: offset_valid};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_done", done_read, 0);
    chk("rst_mask", offset_valid, 0);
    chk("rst_frame", frame_to_read, 0);
    chk("rst_idx", hist_idx, 0);
    chk("rst_off0", offset[0], 0);
    #10 reset_N = 1'b1;
    // main case, consumer always ready
    push_case1();
    start(8'd12, 3'd5, 8'd9, 8'd3, 8'd5, 8'd0, 8'd0);
    chk("t1_line_valid_T0p1", line_valid, 0);
    @(posedge clk); #1;
    chk("t1_line_valid_T0p2", line_valid, 1);
    wait_done("t1");
    // frame number wrap
`ifdef OFLOW_HIST_READ_REVERSE_EN
    push_slot(255, 1, 2); push_slot(0, 0, 2);
`else
    push_slot(0, 0, 2); push_slot(255, 1, 2);
`endif
    start(8'd1, 3'd3, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0);
    wait_done("wrap");
    // backpressure 3 low / 1 high
    bp_en = 1'b1;
    push_case1();
    start(8'd12, 3'd5, 8'd9, 8'd3, 8'd5, 8'd0, 8'd0);
    wait_done("bp");
    bp_en = 1'b0;
    // nh = 0
    start(8'd12, 3'd0, 8'd9, 8'd3, 8'd5, 8'd0, 8'd0);
    chk("nh0_done_T0p1", done_read, 0);
    @(posedge clk); #1;
    chk("nh0_done_T0p2", done_read, 1);
    chk("nh0_busy_T0p2", busy, 0);
    done_exp++;
    @(posedge clk); #1;
    chk("nh0_done_one_cycle", done_read, 0);
    // nh = 7 clamps to 5 slots
`ifdef OFLOW_HIST_READ_REVERSE_EN
    for (int s = 4; s >= 0; s--) push_slot(11 - s, s, 1);
`else
    for (int s = 0; s < 5; s++) push_slot(11 - s, s, 1);
`endif
    start(8'd12, 3'd7, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    wait_done("nh7");
    // abort on the first transfer of slot 1
`ifdef OFLOW_HIST_READ_REVERSE_EN
    push_slot(9, 2, 5);
`else
    push_slot(11, 0, 9);
`endif
    start(8'd12, 3'd5, 8'd9, 8'd3, 8'd5, 8'd0, 8'd0);
    for (int i = 0; i < 100 && !(line_valid && hist_idx == 3'd1); i++) begin
      @(posedge clk); #1;
    end
    chk("abort_slot1_reached", {line_valid, hist_idx}, {1'b1, 3'd1});
    chk("abort_slot1_base", offset[0], 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_line_valid", line_valid, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    chk("abort_no_done", done_read, 0);
    chk("abort_lines_left", q.size(), 0);
    push_case1();
    start(8'd12, 3'd5, 8'd9, 8'd3, 8'd5, 8'd0, 8'd0);
    wait_done("restart");
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_seen, done_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
